// File: rtl/nios_oci_trace_pkg.sv
// Shared constants for the OCI data-trace capture buffer: FSM encoding, default sizing, counter ceiling.
package nios_oci_trace_pkg;

    localparam int SLOT_W_DEF = 10;
    localparam int SLOTS_DEF  = 3;
    localparam int DEPTH_DEF  = 16;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    typedef logic [1:0] state_t;
    localparam state_t ST_CAPTURE = 2'd0;
    localparam state_t ST_DRAIN   = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/nios_oci_trace_fifo.sv
// Multi-write (up to SLOTS frames per cycle), single-read, first-word-fall-through frame FIFO.
// Writer must only push when room exists; head frame reads as 0 while empty.
module nios_oci_trace_fifo #(
    parameter int SLOT_W = 10,
    parameter int SLOTS  = 3,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_vld,
    input  logic [CNT_W-1:0]           wr_cnt,
    input  logic [SLOTS*SLOT_W-1:0]    wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [SLOT_W-1:0]          rd_dat,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [SLOT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              pop;

    // Storage is deliberately not reset; only pointers and level are.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (i < int'(wr_cnt))
                    mem_q[wr_ptr_q + PTR_W'(i)] <= wr_dat[i*SLOT_W +: SLOT_W];
            end
        end
    end

    always_comb begin
        pop      = rd_rdy && (level_q != '0);
        wr_ptr_d = wr_ptr_q + (wr_vld ? PTR_W'(wr_cnt) : '0);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + (wr_vld ? LVL_W'(wr_cnt) : '0) - LVL_W'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_vld = (level_q != '0);
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
    assign level  = level_q;

endmodule

// File: rtl/nios_oci_trace_capture.sv
// Captures packed data-trace frame groups into a FIFO and streams them out one frame per handshake.
// Whole groups are dropped (and counted) when the registered free space is short; output is valid/ready.
module nios_oci_trace_capture
    import nios_oci_trace_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF,
    parameter int SLOTS  = SLOTS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(SLOTS + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SLOTS*SLOT_W-1:0]   dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      dct_valid,
    input  logic                      test_ending,
    output logic [SLOT_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [15:0]               overflow_cnt,
    output logic                      capture_done
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic [15:0]       ovf_q, ovf_d;
    logic              capture_done_q, capture_done_d;
    logic [CNT_W-1:0]  grp_n;
    logic [LVL_W-1:0]  free_n;
    logic              grp_vld;
    logic              accept;

    // Room is judged on the registered level; a same-cycle pop never creates space.
    always_comb begin
        grp_n   = (int'(dct_count) > SLOTS) ? CNT_W'(SLOTS) : dct_count;
        free_n  = LVL_W'(DEPTH) - level;
        grp_vld = (state_q == ST_CAPTURE) && dct_valid && (grp_n != '0);
        accept  = grp_vld && (free_n >= LVL_W'(grp_n));
    end

    always_comb begin
        ovf_d = ovf_q;
        if (grp_vld && !accept && (ovf_q != OVF_MAX))
            ovf_d = ovf_q + 16'd1;

        state_d = state_q;
        case (state_q)
            ST_CAPTURE: if (test_ending) state_d = ST_DRAIN;
            ST_DRAIN:   if (level == '0) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_CAPTURE;
        endcase

        capture_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_CAPTURE;
            ovf_q          <= '0;
            capture_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ovf_q          <= ovf_d;
            capture_done_q <= capture_done_d;
        end
    end

    nios_oci_trace_fifo #(
        .SLOT_W (SLOT_W),
        .SLOTS  (SLOTS),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (accept),
        .wr_cnt  (grp_n),
        .wr_dat  (dct_buffer),
        .rd_rdy  (out_ready),
        .rd_vld  (out_valid),
        .rd_dat  (out_data),
        .level   (level)
    );

    assign overflow_cnt = ovf_q;
    assign capture_done = capture_done_q;

endmodule

// File: tb/tb_nios_oci_trace_capture.sv
// Directed bench for nios_oci_trace_capture: queue-based reference model plus literal spot checks.
module tb_nios_oci_trace_capture;
    localparam int SLOT_W = 10;
    localparam int SLOTS  = 3;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [SLOTS*SLOT_W-1:0] dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    dct_valid;
    logic                    test_ending;
    logic [SLOT_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [4:0]              level;
    logic [15:0]             overflow_cnt;
    logic                    capture_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios_oci_trace_capture #(
        .SLOT_W(SLOT_W), .SLOTS(SLOTS), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .dct_valid    (dct_valid),
        .test_ending  (test_ending),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow_cnt (overflow_cnt),
        .capture_done (capture_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame queue, an unbounded drop tally and a phase (0 capture, 1 drain, 2 done).
    logic [SLOT_W-1:0] mq[$];
    int m_ovf   = 0;
    int m_phase = 0;
    int m_lvl;
    int m_n;

    always @(negedge reset_n) begin
        mq.delete();
        m_ovf   = 0;
        m_phase = 0;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            m_lvl = mq.size();
            if (m_lvl > 0 && out_ready) void'(mq.pop_front());
            if (m_phase == 0 && dct_valid) begin
                m_n = (int'(dct_count) > SLOTS) ? SLOTS : int'(dct_count);
                if (m_n > 0) begin
                    if (DEPTH - m_lvl >= m_n) begin
                        for (int i = 0; i < m_n; i++) mq.push_back(dct_buffer[i*SLOT_W +: SLOT_W]);
                    end else begin
                        m_ovf++;
                    end
                end
            end
            if (m_phase == 0 && test_ending) m_phase = 1;
            else if (m_phase == 1 && m_lvl == 0) m_phase = 2;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
        chk("level", level, mq.size());
        chk("overflow_cnt", overflow_cnt, (m_ovf > 65535) ? 65535 : m_ovf);
        chk("capture_done", capture_done, m_phase == 2);
    end

    initial begin
        reset_n     = 1'b0;
        dct_buffer  = '0;
        dct_count   = '0;
        dct_valid   = 1'b0;
        test_ending = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        chk("rst_done", capture_done, 0);
        reset_n = 1'b1;

        // One full group streamed straight through
        out_ready  = 1'b1;
        dct_valid  = 1'b1;
        dct_count  = 2'd3;
        dct_buffer = {10'h0C3, 10'h0B2, 10'h0A1};
        @(negedge clk);
        dct_valid = 1'b0;
        chk("t1_slot0", out_data, 10'h0A1);
        @(negedge clk);
        chk("t1_slot1", out_data, 10'h0B2);
        @(negedge clk);
        chk("t1_slot2", out_data, 10'h0C3);
        @(negedge clk);
        chk("t1_empty", level, 0);

        // Fill to 15, then a group of 2 cannot fit, a group of 1 can
        out_ready = 1'b0;
        dct_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dct_count  = 2'd3;
            dct_buffer = {SLOT_W'(3*k + 18), SLOT_W'(3*k + 17), SLOT_W'(3*k + 16)};
            @(negedge clk);
        end
        chk("fill_level", level, 15);
        dct_count  = 2'd2;
        dct_buffer = {10'h0, 10'h2EE, 10'h2DD};
        @(negedge clk);
        chk("drop2_ovf", overflow_cnt, 1);
        chk("drop2_level", level, 15);
        dct_count  = 2'd1;
        dct_buffer = {10'h0, 10'h0, 10'h3A5};
        @(negedge clk);
        chk("fit1_level", level, 16);

        // Full with a simultaneous pop: pop does not make room
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_level", level, 15);
        chk("full_pop_ovf", overflow_cnt, 2);
        out_ready = 1'b0;
        dct_count = 2'd0;
        @(negedge clk);
        chk("zero_cnt_ovf", overflow_cnt, 2);

        // Saturate the drop counter
        dct_count = 2'd3;
        repeat (65540) @(negedge clk);
        chk("sat_ovf", overflow_cnt, 16'hFFFF);
        chk("sat_level", level, 15);

        // Leave 5 stored, end the test with a 2-frame group in the same cycle
        dct_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        chk("pre_end_level", level, 5);
        test_ending = 1'b1;
        dct_valid   = 1'b1;
        dct_count   = 2'd2;
        dct_buffer  = {10'h0, 10'h1F2, 10'h1F1};
        @(negedge clk);
        chk("end_group_level", level, 7);
        test_ending = 1'b0;
        dct_count   = 2'd3;
        out_ready   = 1'b1;
        repeat (7) @(negedge clk);
        chk("drain_level", level, 0);
        chk("drain_not_done", capture_done, 0);
        @(negedge clk);
        chk("drain_done", capture_done, 1);
        chk("drain_ovf", overflow_cnt, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("done_ignores_grp", level, 0);

        // Reset in the middle of a drain with 4 frames stored
        reset_n   = 1'b0;
        dct_valid = 1'b0;
        @(negedge clk);
        chk("rst2_ovf", overflow_cnt, 0);
        chk("rst2_done", capture_done, 0);
        reset_n    = 1'b1;
        out_ready  = 1'b0;
        dct_valid  = 1'b1;
        dct_count  = 2'd3;
        dct_buffer = {10'h013, 10'h012, 10'h011};
        @(negedge clk);
        dct_count  = 2'd1;
        dct_buffer = {10'h0, 10'h0, 10'h014};
        @(negedge clk);
        dct_valid   = 1'b0;
        test_ending = 1'b1;
        @(negedge clk);
        test_ending = 1'b0;
        chk("mid_drain_level", level, 4);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_level", level, 0);
        chk("async_done", capture_done, 0);
        @(negedge clk);
        reset_n    = 1'b1;
        dct_valid  = 1'b1;
        dct_count  = 2'd3;
        dct_buffer = {10'h023, 10'h022, 10'h021};
        @(negedge clk);
        dct_valid = 1'b0;
        chk("post_rst_capture", level, 3);
        chk("post_rst_head", out_data, 10'h021);

        // Empty FIFO at end of test: done two edges after the sample
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_empty", level, 0);
        test_ending = 1'b1;
        @(negedge clk);
        test_ending = 1'b0;
        chk("t7_not_done", capture_done, 0);
        @(negedge clk);
        chk("t7_done", capture_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
